// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register.
// The state encoding matches the valid bits as {skid_v, main_v}.
package pipe_pkg;

  localparam int PIPE_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_FULL    = 2'b01,
    ST_ILLEGAL = 2'b10,
    ST_SKID    = 2'b11
  } pipe_state_t;

endpackage

// File: rtl/pipe_data_slot.sv
// One payload register with async reset to RESET_VAL, load enable and clear.
// When load and clear are both high, clear wins.
module pipe_data_slot #(
  parameter int               WIDTH     = pipe_pkg::PIPE_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (clear) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: valid/ready handshake, two-entry skid buffer, sync flush.
// Define PIPE_SKID_BUBBLE_CLR_EN to force invalid data slots to RESET_VAL.
//
// state    | meaning
// EMPTY    | no entry held
// FULL     | main slot holds the oldest entry
// SKID     | main and skid both hold entries; skid is younger, in_ready low
// ILLEGAL  | skid without main; unreachable, recovers to EMPTY
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  pipe_state_t      state;
  pipe_state_t      state_n;
  logic             main_v;
  logic             skid_v;
  logic             in_xfer;
  logic             out_xfer;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic             main_clr;
  logic             skid_clr;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] main_in;

  assign main_v    = state[0];
  assign skid_v    = state[1];
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_v && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      // Flush drops the incoming beat; an out-transfer this cycle was still taken.
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_n   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_n   = ST_SKID;
          end else if (out_xfer) begin
            state_n = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_n        = ST_FULL;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  assign main_in = main_from_skid ? skid_d : in_data;

`ifdef PIPE_SKID_BUBBLE_CLR_EN
  assign main_clr = !state_n[0];
  assign skid_clr = skid_v && !state_n[1];
`else
  assign main_clr = 1'b0;
  assign skid_clr = 1'b0;
`endif

  pipe_data_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_in),
    .q     (main_d)
  );

  pipe_data_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_data),
    .q     (skid_d)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (WIDTH 32, RESET_VAL 0).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid cyc %0d got %b exp 0", i, out_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready cyc %0d got %b exp 1", i, in_ready); end
      vectors++;
      if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data cyc %0d got %h exp 0", i, out_data); end
    end
    reset = 1'b0; in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_capture got %b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready beat %0d got %b exp 1", i, in_ready); end
      in_valid = 1'b1; in_data = 32'(i);
      step();
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_out_valid beat %0d got %b exp 1", i, out_valid); end
      vectors++;
      if (out_data !== 32'(i)) begin miscompares++; $display("FAIL stream_out_data beat %0d got %0d exp %0d", i, out_data, i); end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd10;
    step();
    vectors++;
    if (out_data !== 32'd10 || in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_first got data %0d rdy %b exp 10 1", out_data, in_ready); end
    in_data = 32'd11;
    step();
    vectors++;
    if (in_ready !== 1'b0 || out_data !== 32'd10) begin miscompares++; $display("FAIL skid_full got rdy %b data %0d exp 0 10", in_ready, out_data); end
    in_data = 32'd12;
    step();
    vectors++;
    if (in_ready !== 1'b0 || out_data !== 32'd10 || out_valid !== 1'b1) begin miscompares++; $display("FAIL skid_hold got rdy %b data %0d vld %b exp 0 10 1", in_ready, out_data, out_valid); end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_data !== 32'd11 || in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_drain1 got data %0d rdy %b exp 11 1", out_data, in_ready); end
    step();
    vectors++;
    if (out_data !== 32'd12 || out_valid !== 1'b1) begin miscompares++; $display("FAIL skid_drain2 got data %0d vld %b exp 12 1", out_data, out_valid); end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5;
    step();
    vectors++;
    if (out_data !== 32'd5) begin miscompares++; $display("FAIL simul_load got %0d exp 5", out_data); end
    in_data = 32'd6; out_ready = 1'b1;
    step();
    vectors++;
    if (out_data !== 32'd6 || out_valid !== 1'b1) begin miscompares++; $display("FAIL simul_data got data %0d vld %b exp 6 1", out_data, out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL simul_no_skid got rdy %b exp 1", in_ready); end
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL simul_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd20;
    step();
    in_data = 32'd21;
    step();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_pre_skid got rdy %b exp 0", in_ready); end
    flush = 1'b1; in_data = 32'd7;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_state got vld %b rdy %b exp 0 1", out_valid, in_ready); end
`ifdef PIPE_SKID_BUBBLE_CLR_EN
    vectors++;
    if (out_data !== 32'h0) begin miscompares++; $display("FAIL flush_bubble got %h exp 0", out_data); end
`endif
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped cyc %0d got vld %b data %0d exp 0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd30;
    step();
    in_data = 32'd31;
    step();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL areset_pre got rdy %b vld %b exp 0 1", in_ready, out_valid); end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_immediate got vld %b rdy %b exp 0 1", out_valid, in_ready); end
    vectors++;
    if (out_data !== 32'h0) begin miscompares++; $display("FAIL areset_data got %h exp 0", out_data); end
    in_valid = 1'b0;
    step();
    reset = 1'b0; in_valid = 1'b1; in_data = 32'd40; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'd40) begin miscompares++; $display("FAIL areset_resume got vld %b data %0d exp 1 40", out_valid, out_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_simultaneous();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised elastic pipeline register for the pipelined datapath.
- Provides a valid/ready handshake, a built-in two-entry skid buffer and a synchronous flush.
- Replaces plain enable/clear pipeline flops between stages, so backpressure no longer has to be fanned out combinationally across the whole pipeline.
- Full throughput: one transfer per cycle; one-cycle forward latency.

Parameters:
- WIDTH, 32: payload width in bits (instruction/control/data bundle of a stage).
- RESET_VAL, 0: value loaded into both data slots on reset (WIDTH bits, zero-extended).

Ports:
- clk       input   1      clock, all state updates on rising edge.
- reset     input   1      reset, asynchronous, active-high.
- flush     input   1      synchronous kill of all held entries (branch mispredict/exception).
- in_valid  input   1      upstream presents in_data.
- in_ready  output  1      block can accept; a transfer occurs when in_valid && in_ready.
- in_data   input   WIDTH  upstream payload.
- out_valid output  1      out_data is valid.
- out_ready input   1      downstream accepts; a transfer occurs when out_valid && out_ready.
- out_data  output  WIDTH  payload from the main slot.

Behaviour:
- State: main slot (main_v, main_d) and skid slot (skid_v, skid_d). out_valid = main_v, out_data = main_d, in_ready = !skid_v.
- in_ready depends only on registered state, never combinationally on out_ready.
- Reset (async): main_v = skid_v = 0; main_d = skid_d = RESET_VAL. Hence out_valid = 0, in_ready = 1, out_data = RESET_VAL.
- FSM (encoded from {skid_v, main_v}):
  - EMPTY (0,0): on in-transfer, main <= in_data, go FULL. Otherwise stay.
  - FULL (0,1):
    - in-transfer and out-transfer: main <= in_data, stay FULL.
    - in-transfer only: skid <= in_data, go SKID.
    - out-transfer only: go EMPTY.
    - neither: hold.
  - SKID (1,1): in_ready = 0. On out-transfer: main <= skid_d, skid_v <= 0, go FULL. Otherwise hold.
- Ordering: FIFO; the skid entry is always older than any later input.
- Latency: data accepted at edge N is visible on out_data after edge N (i.e. in the next cycle) when the block was EMPTY or FULL with a simultaneous out-transfer.
- Flush: at the next edge main_v <= 0 and skid_v <= 0, i.e. the state goes EMPTY.
  - Any in-transfer in the flush cycle is dropped.
  - Any out-transfer in the flush cycle still counts as taken by downstream.
  - in_ready returns to 1 the cycle after flush.
- Flush has priority over all handshake updates. Reset has priority over flush.
- Reset mid-operation: all entries are discarded immediately, asynchronously.
- Data slots are written only on their load condition; they hold otherwise (subject to the optional feature).
- Illegal encoding (1,0) is unreachable; if entered, the next edge forces EMPTY.

Optional Feature:
- Macro PIPE_SKID_BUBBLE_CLR_EN.
- Defined:
  - Whenever main_v is 0 at the end of an edge (flush, drain to EMPTY), main_d is also forced to RESET_VAL.
  - skid_d is forced to RESET_VAL when skid_v clears.
  - Result: bubbles present a known NOP payload on out_data.
- Undefined: data slots retain stale contents when invalid. out_data is don't-care while out_valid = 0.

Decomposition:
- Shared package pipe_pkg:
  - 2-bit state typedef and localparams ST_EMPTY = 2'b00, ST_FULL = 2'b01, ST_SKID = 2'b11.
  - Default payload width constant PIPE_W = 32.
- One natural sub-module: pipe_data_slot.
  - WIDTH-wide register with async reset to RESET_VAL, load enable and optional clear.
  - Instantiated twice (main, skid).
- The handshake FSM stays in the top module.

Test Plan:
- Reset then idle: assert reset with in_valid = 1, in_data = 32'hDEADBEEF -> out_valid = 0, in_ready = 1, out_data = 0 throughout reset. No capture.
- Streaming: out_ready = 1, send 1,2,3,4 on consecutive cycles -> out_data shows 1,2,3,4 one cycle later, out_valid high 4 cycles, in_ready never drops.
- Backpressure/skid: send 10,11,12 while out_ready = 0 -> 10 in main, 11 in skid, in_ready = 0 on the 3rd cycle so 12 is held upstream. Raise out_ready -> outputs 10,11,12 in order, nothing lost or duplicated.
- Simultaneous in/out in FULL: main = 5, in_data = 6 with both transfers -> next cycle out_data = 6, skid_v stays 0.
- Flush in SKID with in_valid = 1, in_data = 7 -> next cycle out_valid = 0, in_ready = 1, 7 never appears. With PIPE_SKID_BUBBLE_CLR_EN, out_data = RESET_VAL.
- Async reset asserted mid-cycle while in SKID -> out_valid = 0 and in_ready = 1 immediately, without waiting for a clock edge.
